mux_n_1_scan: RTL and testbench



---
 rtl/mux_n_1_scan.sv | 198 +++++++++++++++++++
 tb/tb_mux_n_1_scan.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mux_n_1_scan.sv
// Registered N:1 multiplexer with valid/ready output, manual select and round-robin scan with dwell gap.
// Optional feature: define MUX_SCAN_CHANNEL_MASK_EN to add a per-channel enable mask for scan and manual capture.
module mux_n_1_scan #(
  parameter int NUM_CHANNELS = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int SEL_WIDTH    = 4,
  parameter int DWELL_WIDTH  = 8
) (
  input  logic                               Clock_In,
  input  logic                               Reset_In,
  input  logic                               Enable_In,
  input  logic                               Mode_In,
  input  logic [SEL_WIDTH-1:0]               Select_In,
  input  logic [DWELL_WIDTH-1:0]             Dwell_In,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] Data_In,
  input  logic                               Out_Ready_In,
`ifdef MUX_SCAN_CHANNEL_MASK_EN
  input  logic [NUM_CHANNELS-1:0]            Channel_Mask_In,
`endif
  output logic [DATA_WIDTH-1:0]              MUX_Data_Out,
  output logic                               MUX_Valid_Out,
  output logic [SEL_WIDTH-1:0]               MUX_Channel_Out
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DWELL} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_mode, w_mode_nxt;
  logic                    r_valid, w_valid_nxt;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [SEL_WIDTH-1:0]    r_ch;
  logic [SEL_WIDTH-1:0]    r_ptr, w_ptr_nxt;
  logic [DWELL_WIDTH-1:0]  r_cnt, w_cnt_nxt;

  logic                    w_cap;
  logic [SEL_WIDTH-1:0]    w_cap_ch;
  logic [DATA_WIDTH-1:0]   w_cap_data;
  logic                    w_xfer;
  logic [NUM_CHANNELS-1:0] w_mask;
  logic                    w_first_ok, w_adv_ok;
  logic [SEL_WIDTH-1:0]    w_first_ch, w_adv_ch;

`ifdef MUX_SCAN_CHANNEL_MASK_EN
  assign w_mask = Channel_Mask_In;
`else
  assign w_mask = '1;
`endif

  assign w_xfer = r_valid & Out_Ready_In;

  // Circular search for the next enabled channel starting at base+off; MSB of result flags a hit.
  function automatic logic [SEL_WIDTH:0] f_search(input logic [NUM_CHANNELS-1:0] mask,
                                                  input logic [SEL_WIDTH-1:0]    base,
                                                  input int                      off);
    logic                 found;
    logic [SEL_WIDTH-1:0] idx;
    int                   k;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      k = (int'(base) + i + off) % NUM_CHANNELS;
      if (!found && mask[k]) begin
        found = 1'b1;
        idx   = SEL_WIDTH'(k);
      end
    end
    return {found, idx};
  endfunction

  assign {w_first_ok, w_first_ch} = f_search(w_mask, '0, 0);
  assign {w_adv_ok, w_adv_ch}     = f_search(w_mask, r_ptr, 1);

  // Out-of-range or masked channels yield zero data while still reporting the requested index.
  always_comb begin
    w_cap_data = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (w_cap_ch == SEL_WIDTH'(k) && w_mask[k])
        w_cap_data = Data_In[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // State register
  always_ff @(posedge Clock_In) begin
    if (Reset_In) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (Enable_In && (!Mode_In || w_first_ok)) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (!Enable_In) w_state_nxt = S_IDLE;
        else if (w_xfer && r_mode) begin
          if (Dwell_In != '0) w_state_nxt = S_DWELL;
          else if (!w_adv_ok) w_state_nxt = S_IDLE;
        end
      end
      S_DWELL: begin
        if (!Enable_In) w_state_nxt = S_IDLE;
        else if (r_cnt <= DWELL_WIDTH'(1)) w_state_nxt = w_adv_ok ? S_HOLD : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath control
  always_comb begin
    w_cap       = 1'b0;
    w_cap_ch    = r_ch;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_mode_nxt  = r_mode;
    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        if (Enable_In) begin
          w_mode_nxt = Mode_In;
          if (!Mode_In) begin
            w_cap       = 1'b1;
            w_cap_ch    = Select_In;
            w_valid_nxt = 1'b1;
          end else if (w_first_ok) begin
            w_cap       = 1'b1;
            w_cap_ch    = w_first_ch;
            w_ptr_nxt   = w_first_ch;
            w_valid_nxt = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (!Enable_In) w_valid_nxt = 1'b0;
        else if (w_xfer) begin
          if (!r_mode) begin
            w_cap    = 1'b1;
            w_cap_ch = Select_In;
          end else if (Dwell_In != '0) begin
            w_cnt_nxt   = Dwell_In;
            w_valid_nxt = 1'b0;
          end else if (w_adv_ok) begin
            w_cap     = 1'b1;
            w_cap_ch  = w_adv_ch;
            w_ptr_nxt = w_adv_ch;
          end else begin
            w_valid_nxt = 1'b0;
          end
        end
      end
      S_DWELL: begin
        w_valid_nxt = 1'b0;
        if (Enable_In) begin
          if (r_cnt <= DWELL_WIDTH'(1)) begin
            w_cnt_nxt = '0;
            if (w_adv_ok) begin
              w_cap       = 1'b1;
              w_cap_ch    = w_adv_ch;
              w_ptr_nxt   = w_adv_ch;
              w_valid_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt - DWELL_WIDTH'(1);
          end
        end
      end
      default: w_valid_nxt = 1'b0;
    endcase
  end

  // Datapath registers; data/channel persist after valid drops.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      r_mode  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_cap) begin
        r_data <= w_cap_data;
        r_ch   <= w_cap_ch;
      end
    end
  end

  assign MUX_Data_Out    = r_data;
  assign MUX_Valid_Out   = r_valid;
  assign MUX_Channel_Out = r_ch;

endmodule

// File: tb/tb_mux_n_1_scan.sv
// Directed bench for mux_n_1_scan: vector table for manual mode plus hand-written scan/reset sequences.
module tb_mux_n_1_scan;

  localparam int NC = 16;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int WW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            en, mode, rdy;
  logic [SW-1:0]   sel;
  logic [WW-1:0]   dwell;
  logic [NC*DW-1:0] din;
  logic [DW-1:0]   dout;
  logic            vout;
  logic [SW-1:0]   chout;
`ifdef MUX_SCAN_CHANNEL_MASK_EN
  logic [NC-1:0]   mask;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_n_1_scan #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .DWELL_WIDTH(WW)) dut (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Mode_In(mode),
    .Select_In(sel), .Dwell_In(dwell), .Data_In(din), .Out_Ready_In(rdy),
`ifdef MUX_SCAN_CHANNEL_MASK_EN
    .Channel_Mask_In(mask),
`endif
    .MUX_Data_Out(dout), .MUX_Valid_Out(vout), .MUX_Channel_Out(chout)
  );

  typedef struct {
    logic          en;
    logic          mode;
    logic [SW-1:0] sel;
    logic          rdy;
    logic          ev;
    logic [DW-1:0] ed;
    logic [SW-1:0] ec;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic ev, input logic [DW-1:0] ed, input logic [SW-1:0] ec);
    chk({nm, ".valid"}, 32'(vout), 32'(ev));
    chk({nm, ".data"},  32'(dout), 32'(ed));
    chk({nm, ".ch"},    32'(chout), 32'(ec));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NC; k++) din[k*DW +: DW] = DW'(8'h10 + k);
    rst = 1'b1; en = 1'b0; mode = 1'b0; rdy = 1'b0; sel = '0; dwell = '0;
`ifdef MUX_SCAN_CHANNEL_MASK_EN
    mask = '1;
`endif

    // en, mode, sel, rdy -> expected valid, data, channel after the edge
    vecs[0] = '{1'b1, 1'b0, 4'd3,  1'b1, 1'b1, 8'h13, 4'd3};
    vecs[1] = '{1'b1, 1'b0, 4'd7,  1'b1, 1'b1, 8'h17, 4'd7};
    vecs[2] = '{1'b1, 1'b0, 4'd15, 1'b1, 1'b1, 8'h1F, 4'd15};
    vecs[3] = '{1'b1, 1'b0, 4'd2,  1'b0, 1'b1, 8'h1F, 4'd15};
    vecs[4] = '{1'b1, 1'b0, 4'd9,  1'b0, 1'b1, 8'h1F, 4'd15};
    vecs[5] = '{1'b1, 1'b0, 4'd4,  1'b0, 1'b1, 8'h1F, 4'd15};
    vecs[6] = '{1'b1, 1'b0, 4'd1,  1'b0, 1'b1, 8'h1F, 4'd15};
    vecs[7] = '{1'b1, 1'b0, 4'd6,  1'b1, 1'b1, 8'h16, 4'd6};
    vecs[8] = '{1'b0, 1'b0, 4'd6,  1'b1, 1'b0, 8'h16, 4'd6};

    tick(); tick();
    rst = 1'b0;
    chk_out("reset", 1'b0, 8'h00, 4'd0);

    for (int i = 0; i < 9; i++) begin
      en = vecs[i].en; mode = vecs[i].mode; sel = vecs[i].sel; rdy = vecs[i].rdy;
      tick();
      chk_out($sformatf("manual[%0d]", i), vecs[i].ev, vecs[i].ed, vecs[i].ec);
    end

    // Reset mid-HOLD on channel 5, with enable still high
    en = 1'b1; mode = 1'b0; sel = 4'd5; rdy = 1'b0;
    tick();
    chk_out("hold5", 1'b1, 8'h15, 4'd5);
    rst = 1'b1;
    tick();
    chk_out("rst_hold", 1'b0, 8'h00, 4'd0);
    rst = 1'b0; en = 1'b0;
    tick();
    chk("rst_idle.valid", 32'(vout), 32'd0);

    // Scan with dwell 2: exactly two idle cycles between samples, wrap 15 -> 0
    mode = 1'b1; dwell = 8'd2; rdy = 1'b1; en = 1'b1;
    tick();
    chk_out("scan2[0]", 1'b1, 8'h10, 4'd0);
    for (int c = 1; c <= NC; c++) begin
      tick();
      chk($sformatf("scan2[%0d].gap1", c), 32'(vout), 32'd0);
      tick();
      chk($sformatf("scan2[%0d].gap2", c), 32'(vout), 32'd0);
      tick();
      chk_out($sformatf("scan2[%0d]", c), 1'b1, DW'(8'h10 + (c % NC)), SW'(c % NC));
    end

    // Scan with dwell 0: new channel every cycle; Mode_In change in HOLD ignored
    en = 1'b0;
    tick();
    chk("scan0.idle", 32'(vout), 32'd0);
    dwell = 8'd0; en = 1'b1;
    tick();
    chk_out("scan0[0]", 1'b1, 8'h10, 4'd0);
    mode = 1'b0; sel = 4'd9;
    tick();
    chk_out("scan0[1]", 1'b1, 8'h11, 4'd1);
    tick();
    chk_out("scan0[2]", 1'b1, 8'h12, 4'd2);
    tick();
    chk_out("scan0[3]", 1'b1, 8'h13, 4'd3);
    // Enter DWELL, then drop enable mid-dwell
    dwell = 8'd3;
    tick();
    chk_out("dwell_in", 1'b0, 8'h13, 4'd3);
    tick();
    chk("dwell_mid.valid", 32'(vout), 32'd0);
    en = 1'b0;
    tick();
    chk("dwell_dis.valid", 32'(vout), 32'd0);
    tick();
    tick();
    chk("dwell_stay.valid", 32'(vout), 32'd0);
    mode = 1'b1; en = 1'b1;
    tick();
    chk_out("restart", 1'b1, 8'h10, 4'd0);

`ifdef MUX_SCAN_CHANNEL_MASK_EN
    do_reset();
    mask = 16'h0024; mode = 1'b1; dwell = 8'd0; rdy = 1'b1; en = 1'b1;
    tick();
    chk_out("mask[0]", 1'b1, 8'h12, 4'd2);
    tick();
    chk_out("mask[1]", 1'b1, 8'h15, 4'd5);
    tick();
    chk_out("mask[2]", 1'b1, 8'h12, 4'd2);
    tick();
    chk_out("mask[3]", 1'b1, 8'h15, 4'd5);
    en = 1'b0;
    tick();
    mask = '0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mask0[%0d].valid", i), 32'(vout), 32'd0);
    end
`else
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
